// File: rtl/disp_scan_if.sv
// Display port bundle for disp_scan: value/control inputs and scanned outputs.
// master = the side that supplies the value (bench or host logic),
// slave  = the scan driver itself.
interface disp_scan_if #(
   parameter int DIGITS = 4
) ();
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                blank;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame;

   // load is a single-cycle strobe sampled on every rising clk edge; there is
   // no ready, the driver always accepts it. blank is a level, sampled only at
   // digit-slot boundaries. frame is a one-cycle pulse after each full scan.
   modport master (
      output data, dp_in, load, blank,
      input  seg, dp, an, frame
   );

   modport slave (
      input  data, dp_in, load, blank,
      output seg, dp, an, frame
   );
endinterface

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed hex 7-segment driver with double-buffered value,
// frame-boundary updates and a per-slot guard interval against ghosting.
// Optional feature: define DISP_LZB_EN for leading-zero blanking.
// state_dbg exposes the OFF/SCAN state for observation.
module disp_scan #(
   parameter int DIGITS = 4,
   parameter int DIV    = 1024,
   parameter int GUARD  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   disp_scan_if.slave  bus,
   output logic [1:0]  state_dbg
);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int AW = 5 * DIGITS;   // {dp[DIGITS-1:0], nibbles}

   logic [PW-1:0] prescaler;
   logic [DW-1:0] digit;
   logic [AW-1:0] shadow;
   logic [AW-1:0] active;
   logic [AW-1:0] next_active;
   logic          pending;
   logic [1:0]    state;
   logic          slot_end;
   logic          frame_end;
   logic          show;
   logic [3:0]    cur_nib;
   logic          cur_dp;
   logic          cur_zero;

   assign slot_end  = (prescaler == PW'(DIV - 1));
   assign frame_end = slot_end && (digit == DW'(DIGITS - 1));
   assign state_dbg = state;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b1110111;
         4'h1: decode = 7'b0100100;
         4'h2: decode = 7'b1011101;
         4'h3: decode = 7'b1101101;
         4'h4: decode = 7'b0101110;
         4'h5: decode = 7'b1101011;
         4'h6: decode = 7'b1111011;
         4'h7: decode = 7'b0100111;
         4'h8: decode = 7'b1111111;
         4'h9: decode = 7'b1101111;
         4'hA: decode = 7'b0111111;
         4'hB: decode = 7'b1111010;
         4'hC: decode = 7'b1010011;
         4'hD: decode = 7'b1111100;
         4'hE: decode = 7'b1011011;
         4'hF: decode = 7'b0011011;
         default: decode = 7'b0000000;
      endcase
   endfunction

   // Value that becomes active at a frame boundary: a same-cycle load wins over
   // a pending shadow; outside boundaries active holds.
   always_comb begin
      next_active = active;
      if (frame_end) begin
         if (bus.load)
            next_active = {bus.dp_in, bus.data};
         else if (pending)
            next_active = shadow;
      end
   end

   // Prescaler counts slot cycles; digit advances on each slot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         digit     <= '0;
      end else if (slot_end) begin
         prescaler <= '0;
         digit     <= (digit == DW'(DIGITS - 1)) ? '0 : digit + 1'b1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Shadow capture and the pending flag; a boundary always clears pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         pending <= 1'b0;
      end else if (frame_end) begin
         pending <= 1'b0;
      end else if (bus.load) begin
         shadow  <= {bus.dp_in, bus.data};
         pending <= 1'b1;
      end
   end

   // Active value only changes at frame boundaries, so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         active <= '0;
      else
         active <= next_active;
   end

   // OFF/SCAN state, evaluated only at slot boundaries so blank acts per slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
      end else if (slot_end) begin
         case (state)
            ST_OFF:  if (!bus.blank) state <= ST_SCAN;
            ST_SCAN: if (bus.blank)  state <= ST_OFF;
            default: state <= ST_OFF;
         endcase
      end
   end

`ifdef DISP_LZB_EN
   logic [DIGITS-1:0] lz_mask;

   // Bit i set when nibble i and every higher nibble are zero; digit 0 never.
   function automatic logic [DIGITS-1:0] lz_of(input logic [4*DIGITS-1:0] v);
      logic all_zero;
      lz_of    = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero && (v[4*i +: 4] == 4'h0);
         lz_of[i] = all_zero;
      end
   endfunction

   // Mask is recomputed from the incoming value at each frame boundary and held
   // for the whole frame; the reset value matches the reset active value of 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lz_mask <= lz_of('0);
      else if (frame_end)
         lz_mask <= lz_of(next_active[4*DIGITS-1:0]);
   end

   assign cur_zero = lz_mask[digit];
`else
   assign cur_zero = 1'b0;
`endif

   // Select the current digit's nibble and decimal point, and the guard window.
   always_comb begin
      cur_nib = active[4*int'(digit) +: 4];
      cur_dp  = active[4*DIGITS + int'(digit)];
      show    = (state == ST_SCAN) && (int'(prescaler) >= GUARD);
   end

   // Registered outputs: one cycle behind the prescaler/digit they reflect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg   <= '0;
         bus.dp    <= 1'b0;
         bus.an    <= '0;
         bus.frame <= 1'b0;
      end else begin
         bus.frame <= frame_end;
         if (show) begin
            bus.an  <= DIGITS'(1) << digit;
            bus.seg <= cur_zero ? 7'b0000000 : decode(cur_nib);
            bus.dp  <= cur_dp;
         end else begin
            bus.an  <= '0;
            bus.seg <= '0;
            bus.dp  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIGITS=4, DIV=8, GUARD=2 (32-cycle frame).
// Outputs are sampled on the falling edge. Builds with or without DISP_LZB_EN.
module tb_disp_scan;
   localparam int DIGITS = 4;
   localparam int DIV    = 8;
   localparam int GUARD  = 2;
   localparam int FRAME  = DIGITS * DIV;
`ifdef DISP_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   disp_scan_if #(.DIGITS(DIGITS)) bus ();

   disp_scan #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // ---------------- reference helpers ----------------
   function automatic logic [6:0] dec(input logic [3:0] n);
      case (n)
         4'h0: dec = 7'b1110111;  4'h1: dec = 7'b0100100;
         4'h2: dec = 7'b1011101;  4'h3: dec = 7'b1101101;
         4'h4: dec = 7'b0101110;  4'h5: dec = 7'b1101011;
         4'h6: dec = 7'b1111011;  4'h7: dec = 7'b0100111;
         4'h8: dec = 7'b1111111;  4'h9: dec = 7'b1101111;
         4'hA: dec = 7'b0111111;  4'hB: dec = 7'b1111010;
         4'hC: dec = 7'b1010011;  4'hD: dec = 7'b1111100;
         4'hE: dec = 7'b1011011;  4'hF: dec = 7'b0011011;
         default: dec = 7'b0000000;
      endcase
   endfunction

   // {an, seg, dp, frame} expected after the k-th edge of a frame (k = 1..32),
   // with the frame's active value val/dpv and the display scanning.
   function automatic logic [12:0] exp_scan(input logic [15:0] val, input logic [3:0] dpv,
                                            input int k);
      int d, p;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic dp_e;
      d = (k - 1) / DIV;
      p = (k - 1) % DIV;
      an_e = 4'b0; seg_e = 7'b0; dp_e = 1'b0;
      if (p >= GUARD) begin
         an_e  = 4'b0001 << d;
         seg_e = dec(val[4*d +: 4]);
         if (LZB && d > 0 && (val >> (4*d)) == 16'h0) seg_e = 7'b0;
         dp_e  = dpv[d];
      end
      exp_scan = {an_e, seg_e, dp_e, (k == FRAME)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_load(input int k, input int ka, input logic [15:0] va, input logic [3:0] dpa,
                             input int kb, input logic [15:0] vb, input logic [3:0] dpb);
      if (k == ka) begin
         bus.load = 1'b1; bus.data = va; bus.dp_in = dpa;
      end else if (k == kb) begin
         bus.load = 1'b1; bus.data = vb; bus.dp_in = dpb;
      end else begin
         bus.load = 1'b0;
      end
   endtask

   // Waits for the frame pulse (bounded); leaves the bench on the falling edge
   // right after a frame boundary. Returns the number of edges waited.
   task automatic wait_frame(input string name, output int waited);
      waited = 0;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk); @(negedge clk);
         waited = i;
         if (bus.frame === 1'b1) break;
      end
      n_checks++;
      if (bus.frame !== 1'b1) begin
         $display("FAIL %s: frame pulse not seen within 80 cycles (frame=%b, required 1)", name, bus.frame);
         n_fails++;
      end
   endtask

   // Checks one whole frame cycle by cycle, starting right after a boundary.
   // Loads may be issued at the falling edge after step ka / kb (0 = on entry).
   task automatic check_frame(input string name, input logic [15:0] val, input logic [3:0] dpv,
                              input int ka, input logic [15:0] va, input logic [3:0] dpa,
                              input int kb, input logic [15:0] vb, input logic [3:0] dpb);
      logic [12:0] got, want;
      drive_load(0, ka, va, dpa, kb, vb, dpb);
      for (int k = 1; k <= FRAME; k++) begin
         @(posedge clk); @(negedge clk);
         got  = {bus.an, bus.seg, bus.dp, bus.frame};
         want = exp_scan(val, dpv, k);
         n_checks++;
         if (got !== want) begin
            $display("FAIL %s step %0d: {an,seg,dp,frame} got %b_%b_%b_%b required %b_%b_%b_%b",
                     name, k, got[12:9], got[8:2], got[1], got[0],
                     want[12:9], want[8:2], want[1], want[0]);
            n_fails++;
         end
         drive_load(k, ka, va, dpa, kb, vb, dpb);
      end
      bus.load = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [12:0] got, want;
      int d, p, waited;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame} !== 13'b0 || state_dbg !== 2'd0) begin
         $display("FAIL reset_values: {an,seg,dp,frame}=%b state=%0d required 0 / 0",
                  {bus.an, bus.seg, bus.dp, bus.frame}, state_dbg);
         n_fails++;
      end
      rst_n = 1'b1;
      // First slot is OFF; SCAN begins at slot 1 (digit 1) after the guard.
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); @(negedge clk);
         d = (k - 1) / DIV;
         p = (k - 1) % DIV;
         want = 13'b0;
         if (d >= 1 && p >= GUARD) begin
            want[12:9] = 4'b0001 << d;
            want[8:2]  = LZB ? 7'b0 : dec(4'h0);
         end
         got = {bus.an, bus.seg, bus.dp, bus.frame};
         n_checks++;
         if (got !== want) begin
            $display("FAIL reset_startup step %0d: {an,seg,dp,frame} got %b required %b", k, got, want);
            n_fails++;
         end
         if (k == 19) begin
            bus.load = 1'b1; bus.data = 16'h1234; bus.dp_in = 4'b1111;
         end else begin
            bus.load = 1'b0;
         end
      end
      // Asynchronous reset mid-scan with a pending load outstanding.
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.an, bus.seg, bus.dp, bus.frame} !== 13'b0) begin
         $display("FAIL reset_midscan: {an,seg,dp,frame}=%b required 0", {bus.an, bus.seg, bus.dp, bus.frame});
         n_fails++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_frame("reset_first_frame", waited);
      n_checks++;
      if (waited != FRAME) begin
         $display("FAIL reset_frame_timing: first frame after %0d cycles, required %0d", waited, FRAME);
         n_fails++;
      end
      // Pending 1234 must have been discarded by the reset.
      check_frame("reset_discard", 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_scan_order();
      check_frame("scan_pre", 16'h0000, 4'b0000, 0, 16'h1234, 4'b0101, -1, 16'h0, 4'h0);
      check_frame("scan_1234", 16'h1234, 4'b0101, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_double_buffer();
      check_frame("db_hold", 16'h1234, 4'b0101, 5, 16'hABCD, 4'b0011, -1, 16'h0, 4'h0);
      check_frame("db_abcd", 16'hABCD, 4'b0011, 3, 16'h1111, 4'b0000, 20, 16'h0F0F, 4'b1000);
      check_frame("db_last_wins", 16'h0F0F, 4'b1000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_collision();
      check_frame("col_pre", 16'h0F0F, 4'b1000, 10, 16'h9999, 4'b0000, 31, 16'h5555, 4'b0110);
      check_frame("col_5555", 16'h5555, 4'b0110, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_blank();
      logic [12:0] got, want;
      int p, waited;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); @(negedge clk);
         p = (k - 1) % DIV;
         want = 13'b0;
         if (k <= DIV && p >= GUARD) want[12:2] = {4'b0001, dec(4'h5)};
         want[0] = (k == FRAME);
         got = {bus.an, bus.seg, bus.dp, bus.frame};
         n_checks++;
         if (got !== want) begin
            $display("FAIL blank step %0d: {an,seg,dp,frame} got %b required %b", k, got, want);
            n_fails++;
         end
         if (k == 12) begin
            n_checks++;
            if (state_dbg !== 2'd0) begin
               $display("FAIL blank_state: state=%0d required 0 (OFF)", state_dbg);
               n_fails++;
            end
         end
         if (k == 3)  bus.blank = 1'b1;
         if (k == 40) bus.blank = 1'b0;
      end
      wait_frame("blank_resume", waited);
      check_frame("after_blank", 16'h5555, 4'b0110, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   task automatic test_lzb();
      check_frame("lzb_pre", 16'h5555, 4'b0110, 0, 16'h0030, 4'b0000, -1, 16'h0, 4'h0);
      check_frame("lzb_0030", 16'h0030, 4'b0000, 0, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
      check_frame("lzb_0000", 16'h0000, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.data  = '0;
      bus.dp_in = '0;
      bus.load  = 1'b0;
      bus.blank = 1'b0;
      test_reset();
      test_scan_order();
      test_double_buffer();
      test_collision();
      test_blank();
      test_lzb();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
